// File: rtl/bsg_acm_sched.sv
// Round-robin front end that time-shares one ACM encryptor core among num_req_p requesters.
// One job (a frame count) is in flight at a time; zero-frame jobs complete without touching the core.
module bsg_acm_sched #(
  parameter int num_req_p         = 4,
  parameter int max_game_length_p = 255,
  localparam int game_len_width_lp = ((max_game_length_p + 1) == 1) ? 1 : $clog2(max_game_length_p + 1),
  localparam int lg_num_req_lp     = (num_req_p == 1) ? 1 : $clog2(num_req_p)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [num_req_p-1:0]                   req_v_i,
  input  logic [num_req_p*game_len_width_lp-1:0] req_frames_i,
  output logic [num_req_p-1:0]                   req_ready_o,
  output logic [num_req_p-1:0]                   resp_v_o,
  input  logic [num_req_p-1:0]                   resp_yumi_i,
  output logic                                   core_v_o,
  output logic [game_len_width_lp-1:0]           core_frames_o,
  input  logic                                   core_ready_i,
  input  logic                                   core_v_i,
  output logic                                   core_yumi_o,
  output logic [lg_num_req_lp-1:0]               owner_o,
  output logic                                   busy_o
);

  typedef enum logic [1:0] {eIDLE, eISSUE, eWAIT, eRESP} state_e;

  state_e                       state_q, state_d;
  logic [lg_num_req_lp-1:0]     ptr_q, ptr_d;
  logic [lg_num_req_lp-1:0]     owner_q, owner_d;
  logic [game_len_width_lp-1:0] frames_q, frames_d;

  logic                         grant_v;
  logic [lg_num_req_lp-1:0]     grant;
  logic [lg_num_req_lp-1:0]     grant_nxt;
  logic [game_len_width_lp-1:0] grant_frames;

  // Scan from ptr_q upward with wrap; the first valid requester found wins.
  always_comb begin
    int unsigned idx;
    int unsigned nidx;
    idx          = 0;
    nidx         = 0;
    grant_v      = 1'b0;
    grant        = '0;
    grant_nxt    = '0;
    grant_frames = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= num_req_p) idx = idx - num_req_p;
      nidx = idx + 1;
      if (nidx == num_req_p) nidx = 0;
      if (!grant_v && req_v_i[idx[lg_num_req_lp-1:0]]) begin
        grant_v      = 1'b1;
        grant        = idx[lg_num_req_lp-1:0];
        grant_nxt    = nidx[lg_num_req_lp-1:0];
        grant_frames = req_frames_i[idx*game_len_width_lp +: game_len_width_lp];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    frames_d    = frames_q;
    req_ready_o = '0;
    resp_v_o    = '0;
    core_v_o    = 1'b0;
    core_yumi_o = 1'b0;
    case (state_q)
      eIDLE: begin
        if (grant_v) begin
          req_ready_o[grant] = 1'b1;
          owner_d            = grant;
          frames_d           = grant_frames;
          ptr_d              = grant_nxt;
          state_d            = (grant_frames != '0) ? eISSUE : eRESP;
        end
      end
      eISSUE: begin
        core_v_o = 1'b1;
        if (core_ready_i) state_d = eWAIT;
      end
      eWAIT: begin
        core_yumi_o = core_v_i;
        if (core_v_i) state_d = eRESP;
      end
      eRESP: begin
        resp_v_o[owner_q] = 1'b1;
        if (resp_yumi_i[owner_q]) state_d = eIDLE;
      end
      default: state_d = eIDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= eIDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      frames_q <= frames_d;
    end
  end

  assign core_frames_o = frames_q;
  assign owner_o       = owner_q;
  assign busy_o        = (state_q != eIDLE);

endmodule
